// File: rtl/sdram_test_pkg.sv
// Shared encodings for the SDRAM pattern tester: pattern modes, FSM states
// and the PRBS-32 Galois LFSR step.
package sdram_test_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WR_REQ   = 3'd2,
    ST_RD_REQ   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1 (tap at bit e-1 for each term x^e).
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Test pattern source: combinational data for the current word, with the
// PRBS state held in a register that is reseeded per pass and stepped per word.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int          AW   = 23,
  parameter int          DW   = 32,
  parameter int          IW   = 8,
  parameter logic [31:0] SEED = 32'hACE1_2D5B
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [IW-1:0] idx,
  input  logic [AW-1:0] addr,
  input  logic          reseed,
  input  logic          advance,
  output logic [DW-1:0] data
);

  logic [31:0] lfsr;
  logic [31:0] bit_pos;

  // PRBS state: load seed at the start of each pass, step once per completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (reseed) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Pattern select for the word currently being written or checked.
  always_comb begin
    bit_pos = 32'(idx) % 32'(DW);
    data    = '0;
    case (mode_t'(mode))
      MODE_ADDR:  data = DW'(addr);
      MODE_WALK:  data = DW'(1) << bit_pos;
      MODE_PRBS:  data = DW'(lfsr);
      MODE_CHECK: data = idx[0] ? DW'({DW{2'b01}}) : DW'({DW{2'b10}});
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test traffic generator: writes a pattern over an address window,
// reads it back, counts mismatches and reports pass/fail.
// Handshake: fpga_req rises with addr/wr_data/wr_en/rd_en stable and holds them
// until a cycle with fpga_ack=1 (rd_data valid that cycle); req then drops for
// exactly one cycle before the next request.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int          FPGA_ADDR_WIDTH = 23,
  parameter int          FPGA_DATA_WIDTH = 32,
  parameter int          START_ADDR      = 0,
  parameter int          NUM_WORDS       = 1024,
  parameter int          ADDR_STRIDE     = 1,
  parameter int          POWER_UP_CYCLES = 32767,
  parameter int          TIMEOUT_CYCLES  = 4095,
  parameter int          ERR_CNT_WIDTH   = 16,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2D5B
) (
  input  logic                       fpga_clk,
  input  logic                       fpga_reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [1:0]                 mode,
  input  logic                       loop_en,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  output logic [FPGA_ADDR_WIDTH-1:0] first_err_addr,
  output logic [FPGA_DATA_WIDTH-1:0] first_err_data,
  output logic [FPGA_ADDR_WIDTH-1:0] fpga_addr,
  output logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data,
  output logic                       fpga_wr_en,
  output logic                       fpga_rd_en,
  output logic                       fpga_req,
  input  logic                       fpga_ack,
  input  logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data,
  output logic [2:0]                 state_dbg
);

  localparam int AW = FPGA_ADDR_WIDTH;
  localparam int DW = FPGA_DATA_WIDTH;
  localparam int IW = $clog2(NUM_WORDS) + 1;
  localparam int PW = $clog2(POWER_UP_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [AW-1:0] START     = AW'(START_ADDR);
  localparam logic [AW-1:0] STRIDE    = AW'(ADDR_STRIDE);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_WORDS - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(POWER_UP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic [1:0]    mode_q;
  logic          loop_q, stop_seen, gap;
  logic [IW-1:0] idx;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] pwr_cnt;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] pat_data;
  logic          req_on, accept, last_word, tmo_hit, start_go, rd_mismatch;
  logic          reseed, advance;

  sdram_pattern_gen #(
    .AW(AW), .DW(DW), .IW(IW), .SEED(LFSR_SEED)
  ) u_gen (
    .clk(fpga_clk), .rst_n(fpga_reset_n), .mode(mode_q), .idx(idx),
    .addr(addr_q), .reseed(reseed), .advance(advance), .data(pat_data)
  );

  assign req_on      = ((state == ST_WR_REQ) || (state == ST_RD_REQ)) && !gap;
  assign accept      = req_on && fpga_ack;
  assign tmo_hit     = req_on && !fpga_ack && (tcnt == TMO_LAST);
  assign last_word   = (idx == IDX_LAST);
  assign start_go    = (state == ST_IDLE) && start;
  assign rd_mismatch = accept && (state == ST_RD_REQ) && (fpga_rd_data != pat_data);

  assign fpga_req     = req_on;
  assign fpga_wr_en   = req_on && (state == ST_WR_REQ);
  assign fpga_rd_en   = req_on && (state == ST_RD_REQ);
  assign fpga_addr    = req_on ? addr_q : '0;
  assign fpga_wr_data = fpga_wr_en ? pat_data : '0;
  assign ready        = (state == ST_IDLE);
  assign busy         = (state == ST_WR_REQ) || (state == ST_RD_REQ) || (state == ST_DONE);
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge fpga_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) state <= ST_PWR_WAIT;
    else               state <= state_nx;
  end

  // Next state plus the pass-restart (reseed) and next-word (advance) strobes.
  always_comb begin
    state_nx = state;
    reseed   = 1'b0;
    advance  = 1'b0;
    case (state)
      ST_PWR_WAIT: if (pwr_cnt == PWR_LAST) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (start_go) begin
          state_nx = ST_WR_REQ;
          reseed   = 1'b1;
        end
      end
      ST_WR_REQ: begin
        if (accept) begin
          if (last_word) begin
            state_nx = ST_RD_REQ;
            reseed   = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_hit) begin
          state_nx = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (accept) begin
          if (!last_word) begin
            advance = 1'b1;
          end else if (loop_q && !(stop_seen || stop)) begin
            state_nx = ST_WR_REQ;
            reseed   = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end else if (tmo_hit) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_PWR_WAIT;
    endcase
  end

  // Sequencing: power-up delay, word index/address, request gap, ack timer, latched controls.
  always_ff @(posedge fpga_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      pwr_cnt   <= '0;
      idx       <= '0;
      addr_q    <= '0;
      gap       <= 1'b0;
      tcnt      <= '0;
      mode_q    <= 2'd0;
      loop_q    <= 1'b0;
      stop_seen <= 1'b0;
    end else begin
      if (state == ST_PWR_WAIT) pwr_cnt <= pwr_cnt + PW'(1);
      if (reseed) begin
        idx    <= '0;
        addr_q <= START;
      end else if (advance) begin
        idx    <= idx + IW'(1);
        addr_q <= addr_q + STRIDE;
      end
      gap <= accept;
      if (!req_on)        tcnt <= '0;
      else if (!fpga_ack) tcnt <= tcnt + TW'(1);
      if (start_go) begin
        mode_q    <= mode;
        loop_q    <= loop_en;
        stop_seen <= 1'b0;
      end else if (busy && stop) begin
        stop_seen <= 1'b1;
      end
    end
  end

  // Result tracking: saturating error count, first failure capture, sticky flags, done pulse.
  always_ff @(posedge fpga_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (start_go) begin
        err_count      <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
      end else begin
        if (rd_mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
          if (err_count == '0) begin
            first_err_addr <= addr_q;
            first_err_data <= fpga_rd_data;
          end
        end
        if (tmo_hit) timeout <= 1'b1;
        if (state == ST_DONE) pass <= (err_count == '0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: behavioural controller with programmable ack
// latency, expected request stream and expected end-of-test results in queues,
// popped and compared by an independent monitor.
module tb_sdram_pattern_tester;

  localparam int          AW     = 23;
  localparam int          DW     = 32;
  localparam int          NW     = 34;
  localparam int          STRIDE = 2;
  localparam int          PWR    = 16;
  localparam int          TMO    = 20;
  localparam int          EW     = 16;
  localparam logic [AW-1:0] START = 23'h100;
  localparam logic [31:0] SEED   = 32'hACE1_2D5B;
  localparam int          TXW    = 2 + AW + DW;
  localparam int          RSW    = EW + AW + DW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          ready, busy, done, pass, timeout;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr, fpga_addr;
  logic [DW-1:0] first_err_data, fpga_wr_data;
  logic          fpga_wr_en, fpga_rd_en, fpga_req;
  logic          fpga_ack = 1'b0;
  logic [DW-1:0] fpga_rd_data = '0;
  logic [2:0]    state_dbg;

  sdram_pattern_tester #(
    .FPGA_ADDR_WIDTH(AW), .FPGA_DATA_WIDTH(DW), .START_ADDR(32'h100),
    .NUM_WORDS(NW), .ADDR_STRIDE(STRIDE), .POWER_UP_CYCLES(PWR),
    .TIMEOUT_CYCLES(TMO), .ERR_CNT_WIDTH(EW), .LFSR_SEED(SEED)
  ) dut (
    .fpga_clk(clk), .fpga_reset_n(rst_n), .start(start), .stop(stop),
    .mode(mode), .loop_en(loop_en), .ready(ready), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .fpga_addr(fpga_addr), .fpga_wr_data(fpga_wr_data), .fpga_wr_en(fpga_wr_en),
    .fpga_rd_en(fpga_rd_en), .fpga_req(fpga_req), .fpga_ack(fpga_ack),
    .fpga_rd_data(fpga_rd_data), .state_dbg(state_dbg)
  );

  // scoreboard state
  logic [TXW-1:0] exp_q[$];
  logic [RSW-1:0] res_q[$];
  int errors = 0;
  int checks = 0;
  int wr_acc = 0, rd_acc = 0, done_cnt = 0;

  // controller model knobs
  int ack_lat = 0, no_ack_wr = -1, corrupt_rd = -1;
  int wr_seen = 0, rd_seen = 0, wait_cnt = 0;
  logic [DW-1:0] mem [int];

  function automatic logic [AW-1:0] waddr(input int i);
    return START + AW'(i * STRIDE);
  endfunction

  function automatic logic [DW-1:0] pat(input int m, input int i);
    logic [31:0] s;
    logic [DW-1:0] one;
    case (m)
      0: return DW'(waddr(i));
      1: begin one = 1; return one << (i % DW); end
      2: begin
        s = SEED;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
      end
      default: return (i % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  task automatic push_writes(input int m, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, waddr(i), pat(m, i)});
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b1, waddr(i), {DW{1'b0}}});
  endtask

  task automatic push_result(input int e, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                             input logic p, input logic t);
    res_q.push_back({EW'(e), fa, fd, p, t});
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // controller model: acks after ack_lat idle cycles, stores writes, returns reads
  initial begin : ctrl_model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fpga_ack = 1'b0;
        wait_cnt = 0;
      end else if (fpga_ack) begin
        fpga_ack = 1'b0;
      end else if (fpga_req) begin
        if (!(fpga_wr_en && wr_seen == no_ack_wr)) begin
          if (wait_cnt >= ack_lat) begin
            wait_cnt = 0;
            fpga_ack = 1'b1;
            if (fpga_wr_en) begin
              mem[int'(fpga_addr)] = fpga_wr_data;
              wr_seen++;
            end else begin
              fpga_rd_data = mem.exists(int'(fpga_addr)) ? mem[int'(fpga_addr)] : '0;
              if (rd_seen == corrupt_rd) fpga_rd_data[0] = ~fpga_rd_data[0];
              rd_seen++;
            end
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: compare each accepted request and each done report against the queues
  initial begin : monitor
    logic [TXW-1:0] got_t, exp_t;
    logic [RSW-1:0] got_r, exp_r;
    forever begin
      @(negedge clk);
      #2;
      if (fpga_req && fpga_ack) begin
        got_t = {fpga_wr_en, fpga_rd_en, fpga_addr, fpga_wr_data};
        if (fpga_wr_en) wr_acc++;
        else            rd_acc++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL txn_unexpected got=%h exp=none", got_t);
        end else begin
          exp_t = exp_q.pop_front();
          if (got_t !== exp_t) begin
            errors++;
            $display("FAIL txn got=%h exp=%h", got_t, exp_t);
          end
        end
      end
      if (done) begin
        done_cnt++;
        got_r = {err_count, first_err_addr, first_err_data, pass, timeout};
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected got=%h exp=none", got_r);
        end else begin
          exp_r = res_q.pop_front();
          if (got_r !== exp_r) begin
            errors++;
            $display("FAIL result got=%h exp=%h", got_r, exp_r);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic start_test(input logic [1:0] m, input logic le);
    wr_seen = 0; rd_seen = 0; wr_acc = 0; rd_acc = 0;
    @(negedge clk);
    mode = m; loop_en = le; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s_no_done got=0 exp=1", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req(input logic level, input int budget);
    int n = 0;
    @(negedge clk); #3;
    while (fpga_req !== level && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk("req_wait", 64'(fpga_req), 64'(level));
  endtask

  task automatic wait_acc(input int wr_target, input int rd_target, input int budget);
    int n = 0;
    @(negedge clk); #3;
    while ((wr_acc < wr_target || rd_acc < rd_target) && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk("acc_wait", 64'(wr_acc >= wr_target && rd_acc >= rd_target), 64'd1);
  endtask

  // releases reset and checks the power-up window (optionally with an early start)
  task automatic powerup_check(input logic early_start);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= PWR; k++) begin
      @(posedge clk); #1;
      if (k == 10 && early_start) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k == PWR - 1) chk("ready_before_pwr", 64'(ready), 64'd0);
      if (k == PWR)     chk("ready_after_pwr", 64'(ready), 64'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_pwr", {61'd0, busy, fpga_req, ready}, {61'd0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stimulus
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {56'd0, ready, busy, done, pass, timeout, fpga_req, fpga_wr_en, fpga_rd_en}, 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_addr", 64'(fpga_addr), 64'd0);
    chk("rst_wr_data", 64'(fpga_wr_data), 64'd0);
    chk("rst_first_err", {9'd0, first_err_addr, first_err_data}, 64'd0);

    // power-up with an ignored start at cycle 10
    powerup_check(1'b1);

    // mode 0, address-as-data, clean readback
    ack_lat = 0;
    push_writes(0, NW); push_reads(NW);
    push_result(0, '0, '0, 1'b1, 1'b0);
    start_test(2'd0, 1'b0);
    wait_done("mode0", 3000);

    // mode 2 PRBS, read of word 5 corrupted in bit 0
    ack_lat = 3; corrupt_rd = 5;
    push_writes(2, NW); push_reads(NW);
    push_result(1, waddr(5), pat(2, 5) ^ 32'h1, 1'b0, 1'b0);
    start_test(2'd2, 1'b0);
    wait_done("prbs_err", 6000);
    corrupt_rd = -1;

    // checkerboard, controller never acks the 3rd write
    begin
      int n;
      ack_lat = 1; no_ack_wr = 2;
      push_writes(3, 2);
      push_result(0, '0, '0, 1'b0, 1'b1);
      start_test(2'd3, 1'b0);
      wait_acc(2, 0, 200);
      wait_req(1'b0, 20);
      wait_req(1'b1, 20);
      n = 0;
      while (fpga_req && n < 100) begin
        @(negedge clk); #3;
        n++;
      end
      chk("tmo_req_len", 64'(n), 64'(TMO));
      wait_done("timeout", 200);
      no_ack_wr = -1;
    end

    // walking-one loop, stop during pass 2 -> exactly two passes
    ack_lat = 0;
    push_writes(1, NW); push_reads(NW);
    push_writes(1, NW); push_reads(NW);
    push_result(0, '0, '0, 1'b1, 1'b0);
    start_test(2'd1, 1'b1);
    wait_acc(NW + 5, NW, 3000);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_done("loop", 3000);
    chk("loop_wr_count", 64'(wr_acc), 64'(2 * NW));
    chk("loop_rd_count", 64'(rd_acc), 64'(2 * NW));

    // reset asserted in the read phase
    ack_lat = 1;
    push_writes(0, NW); push_reads(NW);
    push_result(0, '0, '0, 1'b1, 1'b0);
    start_test(2'd0, 1'b0);
    wait_acc(NW, 3, 3000);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {59'd0, fpga_req, fpga_wr_en, fpga_rd_en, ready, busy}, 64'd0);
    exp_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    powerup_check(1'b0);

    // recovery: checkerboard full pass
    ack_lat = 2;
    push_writes(3, NW); push_reads(NW);
    push_result(0, '0, '0, 1'b1, 1'b0);
    start_test(2'd3, 1'b0);
    wait_done("recover", 6000);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("res_q_empty", 64'(res_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
